program_stepper: RTL and testbench

- Upstream feeder for the 10-bit processor core. It replaces the manual data switches and the manual clock button.
- Holds a small program memory of 10-bit words and presents the current word on D.
- Generates the processor step clock (STEP_CLK), either free-running or single-step.
- Advances its word pointer only when the processor has actually consumed D. This happens on the instruction fetch (IR load) and on immediate fetch (external-data enable).

---
 rtl/program_stepper.sv | 129 ++++++++++++
 tb/tb_program_stepper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/program_stepper.sv
// Program-memory feeder and step-clock generator for the 10-bit processor core.
// It presents the current word on D and moves to the next word only after the processor has consumed it.
module program_stepper #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter int         DIV       = 25_000_000,
    parameter int         PULSE_W   = 4,
    parameter logic [9:0] HALT_WORD = 10'h3FF
) (
    input  logic              CLK50M,
    input  logic              RST,
    input  logic              RUN,
    input  logic              STEP,
    input  logic              TAKE,
    input  logic              LD_EN,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [9:0]        LD_DATA,
    output logic [9:0]        D,
    output logic              STEP_CLK,
    output logic [ADDR_W-1:0] PC,
    output logic              HALTED
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_HALT} state_t;

    logic [9:0]        r_mem [DEPTH];
    logic [9:0]        r_d;
    logic [ADDR_W-1:0] r_pc;
    logic [PW-1:0]     r_presc;
    logic [CW-1:0]     r_pcnt;
    logic              r_step_q;
    logic              r_take_q;
    logic              r_step_clk;
    state_t            r_state;

    state_t            w_state_nxt;
    logic              w_req;
    logic              w_clk_nxt;
    logic              w_take_nxt;
    logic [CW-1:0]     w_pcnt_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;

    // The prescaler free-runs while RUN is high, so requests are exactly DIV cycles
    // apart no matter how long a pulse takes; requests outside IDLE are simply lost.
    assign w_req = RUN ? (r_presc == PW'(DIV - 1)) : (STEP & ~r_step_q);

    always_ff @(posedge CLK50M) begin
        if (LD_EN)
            r_mem[LD_ADDR] <= LD_DATA;
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            r_d      <= '0;
            r_presc  <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_d      <= r_mem[r_pc];
            r_step_q <= STEP;
            if (!RUN || r_presc == PW'(DIV - 1))
                r_presc <= '0;
            else
                r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_step_clk <= 1'b0;
            r_pcnt     <= '0;
            r_take_q   <= 1'b0;
            r_pc       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_clk <= w_clk_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_take_q   <= w_take_nxt;
            r_pc       <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_step_clk;
        w_pcnt_nxt  = r_pcnt;
        w_take_nxt  = r_take_q;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE: begin
                // The sentinel is only checked at request time, so one taken as an immediate never halts.
                if (w_req) begin
                    if (r_d == HALT_WORD) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_HIGH;
                        w_clk_nxt   = 1'b1;
                        w_pcnt_nxt  = '0;
                    end
                end
            end
            S_HIGH: begin
                if (r_pcnt == CW'(PULSE_W - 1)) begin
                    w_take_nxt  = TAKE;
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = S_LOW;
                end else begin
                    w_pcnt_nxt = r_pcnt + CW'(1);
                end
            end
            S_LOW: begin
                if (r_take_q)
                    w_pc_nxt = (r_pc == ADDR_W'(DEPTH - 1)) ? '0 : r_pc + ADDR_W'(1);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    assign D        = r_d;
    assign STEP_CLK = r_step_clk;
    assign PC       = r_pc;
    assign HALTED   = (r_state == S_HALT);

endmodule

// File: tb/tb_program_stepper.sv
// Directed bench for program_stepper with DIV = 8 and PULSE_W = 2.
module tb_program_stepper;
    logic       clk = 1'b0;
    logic       RST = 1'b1, RUN = 1'b0, STEP = 1'b0, TAKE = 1'b0, LD_EN = 1'b0;
    logic [3:0] LD_ADDR = '0;
    logic [9:0] LD_DATA = '0;
    logic [9:0] D;
    logic       STEP_CLK, HALTED;
    logic [3:0] PC;

    int checks = 0;
    int failures = 0;

    program_stepper #(.DEPTH(16), .ADDR_W(4), .DIV(8), .PULSE_W(2), .HALT_WORD(10'h3FF)) dut (
        .CLK50M(clk), .RST(RST), .RUN(RUN), .STEP(STEP), .TAKE(TAKE), .LD_EN(LD_EN),
        .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .D(D), .STEP_CLK(STEP_CLK), .PC(PC), .HALTED(HALTED)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [3:0] a, input logic [9:0] d);
        LD_EN = 1'b1; LD_ADDR = a; LD_DATA = d;
        cyc(1);
        LD_EN = 1'b0;
    endtask

    // Runs n cycles and returns how many sampled cycles had STEP_CLK high.
    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (STEP_CLK) highs++;
        end
    endtask

    initial begin
        int highs, n, t, last;
        logic prev;

        // Reset
        cyc(2);
        chk("rst_stepclk", STEP_CLK, 0);
        chk("rst_pc", PC, 0);
        chk("rst_halted", HALTED, 0);
        chk("rst_d", D, 0);
        RST = 1'b0;

        // Program load; D follows mem[0] one cycle after the write lands
        ld(4'd0, 10'h041);
        cyc(1);
        chk("load_d0", D, 10'h041);
        ld(4'd1, 10'h005);
        ld(4'd2, 10'h3FF);
        for (int a = 3; a < 16; a++) ld(4'(a), 10'(a));
        cyc(2);

        // Single step with TAKE
        TAKE = 1'b1; STEP = 1'b1;
        count_high(8, highs);
        chk("step1_width", highs, 2);
        chk("step1_pc", PC, 1);
        chk("step1_d", D, 10'h005);

        // Single step without TAKE
        STEP = 1'b0; TAKE = 1'b0;
        cyc(2);
        STEP = 1'b1;
        count_high(8, highs);
        chk("step2_width", highs, 2);
        chk("step2_pc", PC, 1);

        // Advance onto the sentinel
        STEP = 1'b0; TAKE = 1'b1;
        cyc(2);
        STEP = 1'b1;
        count_high(8, highs);
        chk("step3_pc", PC, 2);
        chk("step3_d", D, 10'h3FF);

        // Halt
        STEP = 1'b0;
        cyc(2);
        STEP = 1'b1;
        count_high(8, highs);
        chk("halt_nopulse", highs, 0);
        chk("halt_flag", HALTED, 1);
        chk("halt_pc", PC, 2);
        STEP = 1'b0;
        cyc(1);
        STEP = 1'b1; RUN = 1'b1;
        count_high(20, highs);
        chk("halt_sticky_pulses", highs, 0);
        chk("halt_sticky_flag", HALTED, 1);
        RUN = 1'b0; STEP = 1'b0;

        // Remove the sentinel while halted, then reset out of HALT
        ld(4'd2, 10'h002);
        RST = 1'b1;
        cyc(1);
        chk("rst2_halted", HALTED, 0);
        chk("rst2_pc", PC, 0);
        RST = 1'b0;
        cyc(2);

        // Auto run: rising edges every 8 cycles, PC walks and wraps
        RUN = 1'b1; TAKE = 1'b1;
        n = 0; t = 0; last = 0; prev = 1'b0;
        while (n < 18 && t < 400) begin
            cyc(1);
            t++;
            if (STEP_CLK && !prev) begin
                chk("auto_pc", PC, 32'(n % 16));
                if (n > 0) chk("auto_gap", t - last, 8);
                last = t;
                n++;
            end
            prev = STEP_CLK;
        end
        chk("auto_edges", n, 18);

        // Reset in the first high cycle of a taken step
        RST = 1'b1; RUN = 1'b0;
        cyc(1);
        chk("midrst_stepclk", STEP_CLK, 0);
        chk("midrst_pc", PC, 0);
        RST = 1'b0;
        cyc(1);

        // RUN dropped mid-pulse
        RUN = 1'b1; TAKE = 1'b0;
        t = 0;
        while (!STEP_CLK && t < 20) begin
            cyc(1);
            t++;
        end
        chk("rundrop_edge_seen", STEP_CLK, 1);
        RUN = 1'b0;
        count_high(10, highs);
        chk("rundrop_width", highs + 1, 2);
        chk("rundrop_pc", PC, 0);

        // Write hazard on mem[PC], then STEP edges during HIGH are dropped
        ld(4'd0, 10'h2AA);
        chk("wr_d_1cyc", D, 10'h041);
        cyc(1);
        chk("wr_d_2cyc", D, 10'h2AA);
        highs = 0;
        STEP = 1'b1;
        cyc(1);
        if (STEP_CLK) highs++;
        STEP = 1'b0;
        cyc(1);
        if (STEP_CLK) highs++;
        STEP = 1'b1;
        cyc(1);
        if (STEP_CLK) highs++;
        count_high(8, n);
        chk("drop_width", highs + n, 2);
        chk("drop_pc", PC, 0);
        STEP = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
